mips_multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Decodes the opcode and

---
 rtl/mips_multicycle_control_pkg.sv | 76 +++++++
 rtl/mips_multicycle_control_if.sv | 42 ++++
 rtl/mips_multicycle_control_output_decode.sv | 87 ++++++++
 rtl/mips_multicycle_control.sv | 84 ++++++++
 tb/tb_mips_multicycle_control.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg : shared constants for the multicycle MIPS main control FSM.
//   - state_t : FSM state codes (also exported as the 4-bit debug State port)
//   - OP_*    : opcodes recognised by the decoder (IR[31:26])
//   - ALUOP_*, SRCB_*, PCSRC_* : mux/select encodings driven to the datapath
//   - ctrl_t  : one control word, produced by mc_output_decode
//   - isLegalOp : opcode support check used for the IllegalOp pulse
// Optional feature macro: MC_ADDI_EN (adds the addi instruction).
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
    } ctrl_t;

    // addi only counts as supported when the optional feature is built in
    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (ADDI_EN && (op == OP_ADDI));
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control_if : bundle between the main control FSM and the
// multicycle datapath/memory.
//   Op, MemReady           : datapath -> control (opcode, memory handshake)
//   PCWrite..PCSource      : control -> datapath enables and mux selects
//   IllegalOp              : one-cycle pulse on an unsupported opcode
//   State                  : current FSM state, debug only
// Modports: master = control FSM side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] AluOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp,
               PCSource, IllegalOp, State
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp,
               PCSource, IllegalOp, State
    );
endinterface

// File: rtl/mips_multicycle_control_output_decode.sv
// ---------------------------------------------------------------------------
// mc_output_decode : purely combinational State -> control word.
//   state    in  current FSM state
//   memReady in  memory handshake (qualifies IR/PC load during FETCH)
//   op       in  opcode (only looked at in DECODE, for IllegalOp)
//   ctrl     out full control word; anything not set for a state is 0
// Optional feature macro: MC_ADDI_EN (decodes ADDIEX/ADDIWB states).
// ---------------------------------------------------------------------------
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       memReady,
    input  logic [5:0] op,
    output ctrl_t      ctrl
);

    // Every field starts at 0 so unlisted outputs and unreachable codes are quiet.
    // FETCH loads IR and PC only in the cycle memory actually returns the word.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            S_DECODE: begin
                ctrl.aluSrcB   = SRCB_IMMSH;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.illegalOp = !isLegalOp(op);
            end
            S_MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_REG;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.regWrite = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control : main control FSM of the multicycle MIPS datapath.
// Sequences FETCH/DECODE/execute/memory/writeback (3-5 cycles per instruction,
// longer while memory holds MemReady low) and drives every datapath control.
//   clk   in  system clock, rising edge
//   reset in  synchronous active-high reset, forces FETCH (also mid-access)
//   bus   master modport of mips_multicycle_control_if (Op/MemReady in,
//         control word, IllegalOp and debug State out)
// Optional feature macro: MC_ADDI_EN (addi via ADDIEX -> ADDIWB).
// ---------------------------------------------------------------------------
module mips_multicycle_control
    import mc_pkg::*;
(
    input logic                      clk,
    input logic                      reset,
    mips_multicycle_control_if.master bus
);

    state_t state;
    state_t nextState;
    ctrl_t  ctrl;

    // State register; reset wins over every transition, including a stalled access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Memory states hold until MemReady; anything unknown
    // (unsupported opcode, unused state code) drops back to FETCH.
    always_comb begin
        nextState = S_FETCH;
        unique case (state)
            S_FETCH:  nextState = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_RTYPE:     nextState = S_EXEC;
                    OP_BEQ:       nextState = S_BRANCH;
                    OP_J:         nextState = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      nextState = S_ADDIEX;
`endif
                    default:      nextState = S_FETCH;
                endcase
            end
            S_MEMADR: nextState = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nextState = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nextState = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   nextState = S_RWB;
`ifdef MC_ADDI_EN
            S_ADDIEX: nextState = S_ADDIWB;
`endif
            default:  nextState = S_FETCH;
        endcase
    end

    mc_output_decode outputDecode (
        .state    (state),
        .memReady (bus.MemReady),
        .op       (bus.Op),
        .ctrl     (ctrl)
    );

    assign bus.PCWrite     = ctrl.pcWrite;
    assign bus.PCWriteCond = ctrl.pcWriteCond;
    assign bus.IorD        = ctrl.iorD;
    assign bus.MemRead     = ctrl.memRead;
    assign bus.MemWrite    = ctrl.memWrite;
    assign bus.IRWrite     = ctrl.irWrite;
    assign bus.MemtoReg    = ctrl.memtoReg;
    assign bus.RegDst      = ctrl.regDst;
    assign bus.RegWrite    = ctrl.regWrite;
    assign bus.AluSrcA     = ctrl.aluSrcA;
    assign bus.AluSrcB     = ctrl.aluSrcB;
    assign bus.AluOp       = ctrl.aluOp;
    assign bus.PCSource    = ctrl.pcSource;
    assign bus.IllegalOp   = ctrl.illegalOp;
    assign bus.State       = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control : scoreboard bench for mips_multicycle_control.
// The stimulus side walks whole instructions (class -> list of phases, with
// random memory stalls) and pushes the expected control word for every cycle
// it drives; a monitor pops and compares at each falling edge.
// Optional feature macro: MC_ADDI_EN (changes how opcode 001000 is expected).
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
    } obs_t;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3,
                   PH_MEMWB = 4, PH_MEMWR = 5, PH_EXEC = 6, PH_RWB = 7,
                   PH_BRANCH = 8, PH_JUMP = 9, PH_ADDIEX = 10, PH_ADDIWB = 11;

    localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_BEQ = 3, CL_J = 4,
                   CL_ADDI = 5, CL_ILL = 6;

    logic clk;
    logic reset;
    obs_t expQ[$];
    int   checks;
    int   errors;
    int   cycle;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and cycle counter for messages
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Instruction class straight from the opcode table
    function automatic int classOf(input logic [5:0] op);
        case (op)
            6'b100011: return CL_LW;
            6'b101011: return CL_SW;
            6'b000000: return CL_R;
            6'b000100: return CL_BEQ;
            6'b000010: return CL_J;
`ifdef MC_ADDI_EN
            6'b001000: return CL_ADDI;
`endif
            default:   return CL_ILL;
        endcase
    endfunction

    // Expected outputs while sitting in a given phase
    function automatic obs_t expectFor(input int ph, input logic mr, input logic ill);
        obs_t e;
        e = '0;
        e.state = 4'(ph);
        case (ph)
            PH_FETCH:  begin e.memRead = 1; e.aluSrcB = 2'b01; e.irWrite = mr; e.pcWrite = mr; end
            PH_DECODE: begin e.aluSrcB = 2'b11; e.illegalOp = ill; end
            PH_MEMADR: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
            PH_MEMRD:  begin e.memRead = 1; e.iorD = 1; end
            PH_MEMWB:  begin e.regWrite = 1; e.memtoReg = 1; end
            PH_MEMWR:  begin e.memWrite = 1; e.iorD = 1; end
            PH_EXEC:   begin e.aluSrcA = 1; e.aluOp = 2'b10; end
            PH_RWB:    begin e.regWrite = 1; e.regDst = 1; end
            PH_BRANCH: begin e.aluSrcA = 1; e.aluOp = 2'b01; e.pcWriteCond = 1; e.pcSource = 2'b01; end
            PH_JUMP:   begin e.pcWrite = 1; e.pcSource = 2'b10; end
            PH_ADDIEX: begin e.aluSrcA = 1; e.aluSrcB = 2'b10; end
            PH_ADDIWB: begin e.regWrite = 1; end
            default:   e = '0;
        endcase
        return e;
    endfunction

    // One clock of stimulus; ph < 0 means no expectation for this cycle
    task automatic applyStimulus(input int ph, input logic [5:0] op, input logic mr,
                                 input logic rst, input logic ill);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.Op       = op;
        bus.MemReady = mr;
        if (ph >= 0) expQ.push_back(expectFor(ph, mr, ill));
    endtask

    // A memory-waiting phase: some cycles of MemReady low, then one high
    task automatic waitPhase(input int ph, input int stalls, input logic [5:0] op);
        for (int i = 0; i < stalls; i++) applyStimulus(ph, op, 1'b0, 1'b0, 1'b0);
        applyStimulus(ph, op, 1'b1, 1'b0, 1'b0);
    endtask

    function automatic int pick(input int s);
        return (s < 0) ? int'($urandom_range(0, 3)) : s;
    endfunction

    // Whole instruction: stall counts < 0 are randomised; abortMemRd resets inside MEMRD
    task automatic runInstr(input logic [5:0] op, input int fetchStall,
                            input int memStall, input bit abortMemRd);
        int   cls;
        logic ill;
        cls = classOf(op);
        ill = (cls == CL_ILL);
        waitPhase(PH_FETCH, pick(fetchStall), 6'($urandom));
        applyStimulus(PH_DECODE, op, 1'($urandom), 1'b0, ill);
        case (cls)
            CL_LW: begin
                applyStimulus(PH_MEMADR, op, 1'($urandom), 1'b0, 1'b0);
                if (abortMemRd) begin
                    for (int i = 0; i < pick(memStall); i++)
                        applyStimulus(PH_MEMRD, op, 1'b0, 1'b0, 1'b0);
                    applyStimulus(PH_MEMRD, op, 1'b0, 1'b1, 1'b0);
                end else begin
                    waitPhase(PH_MEMRD, pick(memStall), op);
                    applyStimulus(PH_MEMWB, op, 1'($urandom), 1'b0, 1'b0);
                end
            end
            CL_SW: begin
                applyStimulus(PH_MEMADR, op, 1'($urandom), 1'b0, 1'b0);
                waitPhase(PH_MEMWR, pick(memStall), op);
            end
            CL_R: begin
                applyStimulus(PH_EXEC, op, 1'($urandom), 1'b0, 1'b0);
                applyStimulus(PH_RWB, op, 1'($urandom), 1'b0, 1'b0);
            end
            CL_BEQ:  applyStimulus(PH_BRANCH, op, 1'($urandom), 1'b0, 1'b0);
            CL_J:    applyStimulus(PH_JUMP, op, 1'($urandom), 1'b0, 1'b0);
            CL_ADDI: begin
                applyStimulus(PH_ADDIEX, op, 1'($urandom), 1'b0, 1'b0);
                applyStimulus(PH_ADDIWB, op, 1'($urandom), 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    // Compare one observed control word against the expected one
    task automatic checkOutput(input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL ctrlWord cycle=%0d actual=%h (State=%0d) expected=%h (State=%0d)",
                     cycle, act, act.state, exp, exp.state);
        end
    endtask

    // Monitor: the controller presents a control word every cycle, checked mid-cycle
    initial begin
        obs_t act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                act = {bus.State, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                       bus.AluSrcA, bus.AluSrcB, bus.AluOp, bus.PCSource, bus.IllegalOp};
                checkOutput(act, expQ.pop_front());
            end
        end
    end

    // Directed scenarios first, then a random instruction stream
    initial begin
        logic [5:0] op;
        checks       = 0;
        errors       = 0;
        cycle        = 0;
        reset        = 1'b1;
        bus.Op       = 6'b0;
        bus.MemReady = 1'b1;

        applyStimulus(-1, 6'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(PH_FETCH, 6'b0, 1'b1, 1'b1, 1'b0);

        runInstr(6'b100011, 0, 0, 1'b0);
        runInstr(6'b101011, 0, 3, 1'b0);
        runInstr(6'b000000, 0, 0, 1'b0);
        runInstr(6'b000100, 0, 0, 1'b0);
        runInstr(6'b000010, 0, 0, 1'b0);
        runInstr(6'b111111, 0, 0, 1'b0);
        runInstr(6'b001000, 0, 0, 1'b0);
        runInstr(6'b100011, 2, 2, 1'b1);
        runInstr(6'b100011, 2, 2, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                6: op = 6'b111111;
                default: op = 6'($urandom);
            endcase
            runInstr(op, -1, -1, ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d pending expected=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
